// File: rtl/axis_eth_rx_filter_pkg.sv
// Shared Ethernet constants and helpers for the RX frame filter.
// Header layout, well-known ethertypes and parser state encodings.
package axis_eth_rx_filter_pkg;

   localparam int unsigned ETH_HDR_LEN     = 14;
   localparam int unsigned ETH_TYPE_HI_IDX = 12;
   localparam int unsigned ETH_MAC_LEN     = 6;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [47:0] ETH_BCAST_MAC = 48'hffff_ffff_ffff;

   localparam logic [0:0] ST_HDR     = 1'b0;
   localparam logic [0:0] ST_PAYLOAD = 1'b1;

   // Byte i of a MAC address on the wire; byte 0 is the most significant.
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
      logic [7:0] b;
      b = 8'h00;
      unique case (i)
         3'd0:    b = mac[47:40];
         3'd1:    b = mac[39:32];
         3'd2:    b = mac[31:24];
         3'd3:    b = mac[23:16];
         3'd4:    b = mac[15:8];
         3'd5:    b = mac[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/axis_eth_rx_filter_if.sv
// 8-bit AXI4-Stream bus carrying Ethernet bytes with a bad-frame user flag.
interface axis_eth_rx_filter_if;

   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_eth_rx_filter.sv
// Ethernet RX filter: forwards every byte through one register stage and flags frames
// failing the destination-MAC/ethertype check (or runts) with m_drop for the FIFO.
module axis_eth_rx_filter
   import axis_eth_rx_filter_pkg::*;
#(
   parameter bit          MAC_FILTER_ENABLE  = 1'b1,
   parameter bit          ACCEPT_BROADCAST   = 1'b1,
   parameter bit          ACCEPT_MULTICAST   = 1'b0,
   parameter bit          TYPE_FILTER_ENABLE = 1'b1,
   parameter logic [15:0] TYPE0              = ETH_TYPE_IPV4,
   parameter logic [15:0] TYPE1              = ETH_TYPE_ARP,
   parameter int unsigned CNT_WIDTH          = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [47:0]          local_mac,
   axis_eth_rx_filter_if.slave  s_axis,
   axis_eth_rx_filter_if.master m_axis,
   output logic                 m_drop,
   output logic [CNT_WIDTH-1:0] stat_pass_count,
   output logic [CNT_WIDTH-1:0] stat_drop_count
);

   logic [0:0] state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic       ucast_q, ucast_d;
   logic       bcast_q, bcast_d;
   logic       mcast_q, mcast_d;
   logic [7:0] type_hi_q, type_hi_d;

   logic [7:0] tdata_q;
   logic       tvalid_q, tlast_q, tuser_q, drop_q;

   logic        accept, in_hdr, at_type_lo, runt, decide, drop_now;
   logic        mac_ok, type_ok, pass;
   logic [15:0] ethertype;

   assign s_axis.tready = m_axis.tready | ~tvalid_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tuser  = tuser_q;
   assign m_drop        = drop_q;

   always_comb begin
      accept     = s_axis.tvalid & s_axis.tready;
      in_hdr     = (state_q == ST_HDR);
      at_type_lo = in_hdr & (idx_q == 4'(ETH_HDR_LEN - 1));
      ethertype  = {type_hi_q, s_axis.tdata};
      mac_ok     = ~MAC_FILTER_ENABLE | ucast_q | (ACCEPT_BROADCAST & bcast_q)
                   | (ACCEPT_MULTICAST & mcast_q);
      type_ok    = ~TYPE_FILTER_ENABLE | (ethertype == TYPE0) | (ethertype == TYPE1);
      pass       = mac_ok & type_ok;
      // A frame ending before the ethertype is complete can never be classified.
      runt       = in_hdr & s_axis.tlast & ~at_type_lo;
      decide     = accept & (at_type_lo | runt);
      drop_now   = runt | (at_type_lo & ~pass);
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ucast_d   = ucast_q;
      bcast_d   = bcast_q;
      mcast_d   = mcast_q;
      type_hi_d = type_hi_q;
      if (accept) begin
         if (in_hdr) begin
            if (idx_q < 4'(ETH_MAC_LEN)) begin
               ucast_d = ucast_q & (s_axis.tdata == mac_byte(local_mac, idx_q[2:0]));
               bcast_d = bcast_q & (s_axis.tdata == ETH_BCAST_MAC[7:0]);
            end
            if (idx_q == 4'd0) mcast_d = s_axis.tdata[0];
            if (idx_q == 4'(ETH_TYPE_HI_IDX)) type_hi_d = s_axis.tdata;
            if (s_axis.tlast || at_type_lo) begin
               state_d = s_axis.tlast ? ST_HDR : ST_PAYLOAD;
               idx_d   = 4'd0;
               ucast_d = 1'b1;
               bcast_d = 1'b1;
               mcast_d = 1'b1;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end else if (s_axis.tlast) begin
            state_d = ST_HDR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_HDR;
         idx_q     <= 4'd0;
         ucast_q   <= 1'b1;
         bcast_q   <= 1'b1;
         mcast_q   <= 1'b1;
         type_hi_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ucast_q   <= ucast_d;
         bcast_q   <= bcast_d;
         mcast_q   <= mcast_d;
         type_hi_q <= type_hi_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdata_q  <= 8'h00;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         drop_q   <= 1'b0;
      end else if (accept) begin
         tdata_q  <= s_axis.tdata;
         tvalid_q <= 1'b1;
         tlast_q  <= s_axis.tlast;
         tuser_q  <= s_axis.tuser;
         drop_q   <= drop_now;
      end else if (m_axis.tready) begin
         tvalid_q <= 1'b0;
         drop_q   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pass_count <= '0;
         stat_drop_count <= '0;
      end else if (decide) begin
         if (drop_now) begin
            if (stat_drop_count != '1) stat_drop_count <= stat_drop_count + 1'b1;
         end else begin
            if (stat_pass_count != '1) stat_pass_count <= stat_pass_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axis_eth_rx_filter.sv
// Directed and randomized-backpressure bench for axis_eth_rx_filter (CNT_WIDTH=4).
module tb_axis_eth_rx_filter;

   localparam logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01;
   localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;
   localparam logic [47:0] BCAST     = 48'hff_ff_ff_ff_ff_ff;
   localparam logic [47:0] MCAST     = 48'h01_00_5e_00_00_01;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       user;
      logic       drop;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [47:0] local_mac = MY_MAC;
   logic        m_drop;
   logic [3:0]  pass_cnt, drop_cnt;

   axis_eth_rx_filter_if s_if ();
   axis_eth_rx_filter_if m_if ();

   axis_eth_rx_filter #(.CNT_WIDTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .local_mac       (local_mac),
      .s_axis          (s_if),
      .m_axis          (m_if),
      .m_drop          (m_drop),
      .stat_pass_count (pass_cnt),
      .stat_drop_count (drop_cnt)
   );

   always #5 clk = ~clk;

   beat_t in_q[$];
   beat_t out_q[$];
   int    tests = 0;
   int    fails = 0;
   int    exp_pass = 0;
   int    exp_drop = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Builds one frame in wire order and the drop flag the filter should attach to each beat.
   function automatic void push_frame(input logic [47:0] dest, input logic [15:0] etype,
                                      input int len, input logic user);
      beat_t b;
      logic  pass;
      pass = ((dest == local_mac) || (dest == BCAST)) &&
             ((etype == 16'h0800) || (etype == 16'h0806));
      for (int i = 0; i < len; i++) begin
         if (i < 6)        b.data = dest[47 - 8*i -: 8];
         else if (i < 12)  b.data = 8'h10 + 8'(i);
         else if (i == 12) b.data = etype[15:8];
         else if (i == 13) b.data = etype[7:0];
         else              b.data = 8'($urandom);
         b.last = (i == len - 1);
         b.user = user;
         b.drop = (len < 14) ? (i == len - 1) : ((i == 13) && !pass);
         in_q.push_back(b);
      end
      if (len < 14 || !pass) begin
         if (exp_drop < 15) exp_drop++;
      end else begin
         if (exp_pass < 15) exp_pass++;
      end
   endfunction

   task automatic drive(input string name, input int rdy_pct);
      int    ip = 0;
      int    cyc = 0;
      int    bad_lat = 0;
      int    in_cyc[$];
      logic  stall = 1'b0;
      beat_t held;
      beat_t o;
      out_q.delete();
      while ((ip < in_q.size() || out_q.size() < in_q.size()) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         m_if.tready = ($urandom_range(99) < rdy_pct);
         if (ip < in_q.size()) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = in_q[ip].data;
            s_if.tlast  = in_q[ip].last;
            s_if.tuser  = in_q[ip].user;
         end else begin
            s_if.tvalid = 1'b0;
         end
         #1;
         if (stall) begin
            check({name, "_hold_valid"}, 64'(m_if.tvalid), 64'd1);
            check({name, "_hold_beat"}, {m_if.tdata, m_if.tlast, m_if.tuser, m_drop},
                  {held.data, held.last, held.user, held.drop});
         end
         if (s_if.tvalid && s_if.tready) begin
            in_cyc.push_back(cyc);
            ip++;
         end
         stall = 1'b0;
         if (m_if.tvalid) begin
            o.data = m_if.tdata;
            o.last = m_if.tlast;
            o.user = m_if.tuser;
            o.drop = m_drop;
            if (m_if.tready) begin
               out_q.push_back(o);
               if (cyc - in_cyc[out_q.size() - 1] != 1) bad_lat++;
            end else begin
               stall = 1'b1;
               held  = o;
            end
         end
      end
      s_if.tvalid = 1'b0;
      check({name, "_drained"}, 64'(out_q.size() == in_q.size() && ip == in_q.size()), 64'd1);
      if (rdy_pct == 100) check({name, "_latency"}, 64'(bad_lat), 64'd0);
      for (int k = 0; k < out_q.size() && k < in_q.size(); k++) begin
         check($sformatf("%s_beat%0d", name, k),
               {out_q[k].data, out_q[k].last, out_q[k].user, out_q[k].drop},
               {in_q[k].data, in_q[k].last, in_q[k].user, in_q[k].drop});
      end
      check({name, "_pass_cnt"}, 64'(pass_cnt), 64'(exp_pass));
      check({name, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
      in_q.delete();
   endtask

   task automatic check_reset(input string name);
      check({name, "_tvalid"}, 64'(m_if.tvalid), 64'd0);
      check({name, "_tdata"}, 64'(m_if.tdata), 64'd0);
      check({name, "_tlast"}, 64'(m_if.tlast), 64'd0);
      check({name, "_tuser"}, 64'(m_if.tuser), 64'd0);
      check({name, "_drop"}, 64'(m_drop), 64'd0);
      check({name, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
      check({name, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      exp_pass = 0;
      exp_drop = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [47:0] dests[4];
      logic [15:0] types[3];
      dests[0] = MY_MAC;
      dests[1] = OTHER_MAC;
      dests[2] = BCAST;
      dests[3] = MCAST;
      types[0] = 16'h0800;
      types[1] = 16'h0806;
      types[2] = 16'h86dd;
      s_if.tvalid = 1'b0;
      s_if.tdata  = 8'h00;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      m_if.tready = 1'b1;
      #1 rst_n = 1'b0;
      #12;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      push_frame(MY_MAC, 16'h0800, 60, 1'b0);
      drive("ucast_pass", 100);
      push_frame(OTHER_MAC, 16'h0800, 60, 1'b0);
      drive("ucast_drop", 100);
      push_frame(BCAST, 16'h0806, 60, 1'b0);
      drive("bcast_arp", 100);
      push_frame(BCAST, 16'h86dd, 60, 1'b1);
      drive("bcast_v6", 100);
      push_frame(MCAST, 16'h0800, 60, 1'b0);
      drive("mcast", 100);
      push_frame(MY_MAC, 16'h0800, 10, 1'b0);
      push_frame(MY_MAC, 16'h0800, 60, 1'b0);
      drive("runt", 100);
      push_frame(MY_MAC, 16'h0806, 14, 1'b0);
      drive("exact14", 100);

      do_reset();
      for (int f = 0; f < 100; f++) begin
         push_frame(dests[$urandom_range(3)], types[$urandom_range(2)],
                    $urandom_range(24, 8), 1'($urandom));
      end
      drive("rand", 50);

      do_reset();
      for (int f = 0; f < 20; f++) push_frame(OTHER_MAC, 16'h0800, 16, 1'b0);
      drive("sat", 100);
      check("sat_value", 64'(drop_cnt), 64'd15);

      // Partial frame, then reset lands between clock edges mid-payload.
      push_frame(MY_MAC, 16'h0800, 60, 1'b0);
      m_if.tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         s_if.tvalid = 1'b1;
         s_if.tdata  = in_q[i].data;
         s_if.tlast  = in_q[i].last;
         s_if.tuser  = in_q[i].user;
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      s_if.tvalid = 1'b0;
      in_q.delete();
      exp_pass = 0;
      exp_drop = 0;
      @(negedge clk);
      rst_n = 1'b1;
      push_frame(MY_MAC, 16'h0800, 60, 1'b0);
      drive("post_rst", 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
